// File: rtl/d_cmp_pkg.sv
// d_cmp_pkg: shared definitions for the decode-stage branch resolution unit.
//   CMP_*      3-bit compare-mode encodings driven on i_op
//   BHT_RESET  counter value after reset (weakly not-taken)
//   sat2_next  2-bit saturating counter step
package d_cmp_pkg;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LEZ = 3'b010;
  localparam logic [2:0] CMP_GTZ = 3'b011;
  localparam logic [2:0] CMP_LTZ = 3'b100;
  localparam logic [2:0] CMP_GEZ = 3'b101;
  localparam logic [2:0] CMP_LT  = 3'b110;
  localparam logic [2:0] CMP_LTU = 3'b111;

  localparam logic [1:0] BHT_RESET = 2'b01;

  // Count toward 11 on taken and toward 00 on not-taken, sticking at both ends.
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/d_bht.sv
// d_bht: BHT_DEPTH x 2-bit table of saturating branch counters.
//   clk, reset_n  clock / asynchronous active-low reset (all entries -> BHT_RESET)
//   rd_idx/rd_cnt asynchronous read port (fetch lookup), no write bypass
//   we/wr_idx/wr_taken  synchronous saturating update of one entry
module d_bht
  import d_cmp_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int IDXW      = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IDXW-1:0] rd_idx,
  output logic [1:0]      rd_cnt,
  input  logic            we,
  input  logic [IDXW-1:0] wr_idx,
  input  logic            wr_taken
);

  logic [1:0] cnt_q [BHT_DEPTH];
  logic [1:0] cnt_d [BHT_DEPTH];

  // Read returns the registered value, so a same-cycle update is not visible.
  assign rd_cnt = cnt_q[rd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (we) cnt_d[wr_idx] = sat2_next(cnt_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '{default: BHT_RESET};
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/d_branch_cmp.sv
// d_branch_cmp: decode-stage branch resolution.
//   clk, reset_n        clock / asynchronous active-low reset
//   i_f_pc, o_f_pred_taken  fetch-side prediction lookup (MSB of indexed counter)
//   i_valid, i_is_branch, i_op, i_rs, i_rt, i_pc, i_pred_taken  D-stage branch
//   i_stall, i_flush    pipeline control for BHT update and D->E register
//   o_taken, o_mispredict   combinational compare result / mispredict flag
//   o_e_valid, o_e_taken, o_e_mispredict  registered D->E copies
//   o_br_cnt, o_mp_cnt  branch / mispredict statistics; present only when
//                       CMP_STATS_EN is defined, otherwise tied to zero
module d_branch_cmp
  import d_cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PC_LSB    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      i_f_pc,
  output logic             o_f_pred_taken,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic [31:0]      i_pc,
  input  logic             i_pred_taken,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_taken,
  output logic             o_mispredict,
  output logic             o_e_valid,
  output logic             o_e_taken,
  output logic             o_e_mispredict,
  output logic [31:0]      o_br_cnt,
  output logic [31:0]      o_mp_cnt
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  logic [IDXW-1:0] f_idx;
  logic [IDXW-1:0] d_idx;
  logic [1:0]      f_cnt;
  logic            upd;
  logic            rs_zero;
  logic            rs_neg;

  assign f_idx = i_f_pc[PC_LSB +: IDXW];
  assign d_idx = i_pc[PC_LSB +: IDXW];
  assign upd   = i_valid & i_is_branch & ~i_stall;

  // Only the index slice of each PC and the counter MSB are consumed.
  logic unused_bits;
  assign unused_bits = ^{i_f_pc, i_pc, f_cnt[0]};

  d_bht #(
    .BHT_DEPTH(BHT_DEPTH),
    .IDXW     (IDXW)
  ) u_bht (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_idx  (f_idx),
    .rd_cnt  (f_cnt),
    .we      (upd),
    .wr_idx  (d_idx),
    .wr_taken(o_taken)
  );

  assign o_f_pred_taken = f_cnt[1];

  // Zero-compare modes look only at rs.
  assign rs_zero = (i_rs == '0);
  assign rs_neg  = i_rs[WIDTH-1];

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      CMP_EQ:  o_taken = (i_rs == i_rt);
      CMP_NE:  o_taken = (i_rs != i_rt);
      CMP_LEZ: o_taken = rs_neg | rs_zero;
      CMP_GTZ: o_taken = ~rs_neg & ~rs_zero;
      CMP_LTZ: o_taken = rs_neg;
      CMP_GEZ: o_taken = ~rs_neg;
      CMP_LT:  o_taken = ($signed(i_rs) < $signed(i_rt));
      CMP_LTU: o_taken = (i_rs < i_rt);
      default: o_taken = 1'b0;
    endcase
  end

  assign o_mispredict = i_valid & i_is_branch & (o_taken != i_pred_taken);

  // D->E register: flush clears valid only, stall holds everything.
  logic e_valid_q, e_valid_d;
  logic e_taken_q, e_taken_d;
  logic e_mp_q,    e_mp_d;

  always_comb begin
    e_valid_d = e_valid_q;
    e_taken_d = e_taken_q;
    e_mp_d    = e_mp_q;
    if (i_flush) begin
      e_valid_d = 1'b0;
    end else if (!i_stall) begin
      e_valid_d = i_valid;
      e_taken_d = o_taken;
      e_mp_d    = o_mispredict;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid_q <= 1'b0;
      e_taken_q <= 1'b0;
      e_mp_q    <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_taken_q <= e_taken_d;
      e_mp_q    <= e_mp_d;
    end
  end

  assign o_e_valid      = e_valid_q;
  assign o_e_taken      = e_taken_q;
  assign o_e_mispredict = e_mp_q;

`ifdef CMP_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd && br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
    if (upd && o_mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign o_br_cnt = br_cnt_q;
  assign o_mp_cnt = mp_cnt_q;
`else
  assign o_br_cnt = '0;
  assign o_mp_cnt = '0;
`endif

endmodule

// File: tb/tb_d_branch_cmp.sv
module tb_d_branch_cmp;
  import d_cmp_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_f_pc;
  logic        o_f_pred_taken;
  logic        i_valid;
  logic        i_is_branch;
  logic [2:0]  i_op;
  logic [31:0] i_rs;
  logic [31:0] i_rt;
  logic [31:0] i_pc;
  logic        i_pred_taken;
  logic        i_stall;
  logic        i_flush;
  logic        o_taken;
  logic        o_mispredict;
  logic        o_e_valid;
  logic        o_e_taken;
  logic        o_e_mispredict;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mp_cnt;

  int n_cmp;
  int n_err;
  logic [31:0] exp_br;
  logic [31:0] exp_mp;
  logic [7:0]  mode_exp;

  d_branch_cmp #(
    .WIDTH    (32),
    .BHT_DEPTH(16),
    .PC_LSB   (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_f_pc        (i_f_pc),
    .o_f_pred_taken(o_f_pred_taken),
    .i_valid       (i_valid),
    .i_is_branch   (i_is_branch),
    .i_op          (i_op),
    .i_rs          (i_rs),
    .i_rt          (i_rt),
    .i_pc          (i_pc),
    .i_pred_taken  (i_pred_taken),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_taken       (o_taken),
    .o_mispredict  (o_mispredict),
    .o_e_valid     (o_e_valid),
    .o_e_taken     (o_e_taken),
    .o_e_mispredict(o_e_mispredict),
    .o_br_cnt      (o_br_cnt),
    .o_mp_cnt      (o_mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_br = '0;
    exp_mp = '0;
    reset_n = 1'b0;
    i_f_pc = '0; i_valid = 1'b0; i_is_branch = 1'b0; i_op = CMP_EQ;
    i_rs = '0; i_rt = '0; i_pc = '0; i_pred_taken = 1'b0;
    i_stall = 1'b0; i_flush = 1'b0;

    // Reset state
    #22;
    chk("rst_e_valid", {31'd0, o_e_valid}, 32'd0);
    chk("rst_e_taken", {31'd0, o_e_taken}, 32'd0);
    chk("rst_pred", {31'd0, o_f_pred_taken}, 32'd0);
    chk("rst_br_cnt", o_br_cnt, 32'd0);
    chk("rst_mp_cnt", o_mp_cnt, 32'd0);
    reset_n = 1'b1;
    tick();

    // Modes with rs=-1, rt=1; i_valid low, o_taken still computed
    i_rs = 32'hFFFF_FFFF; i_rt = 32'd1;
    mode_exp = 8'b0101_0110;
    for (int i = 0; i < 8; i++) begin
      i_op = 3'(i);
      settle();
      chk($sformatf("mode_neg_op%0d", i), {31'd0, o_taken}, {31'd0, mode_exp[i]});
      chk($sformatf("mode_nomp_op%0d", i), {31'd0, o_mispredict}, 32'd0);
    end
    i_rs = 32'd0;
    i_op = CMP_LEZ; settle(); chk("zero_lez", {31'd0, o_taken}, 32'd1);
    i_op = CMP_GEZ; settle(); chk("zero_gez", {31'd0, o_taken}, 32'd1);
    i_op = CMP_GTZ; settle(); chk("zero_gtz", {31'd0, o_taken}, 32'd0);
    i_op = CMP_LTZ; settle(); chk("zero_ltz", {31'd0, o_taken}, 32'd0);
    i_rs = 32'd1; i_rt = 32'hFFFF_FFFF;
    i_op = CMP_LTU; settle(); chk("ltu_small", {31'd0, o_taken}, 32'd1);
    i_op = CMP_LT;  settle(); chk("lt_pos_vs_neg", {31'd0, o_taken}, 32'd0);
    i_op = CMP_GTZ; settle(); chk("gtz_one", {31'd0, o_taken}, 32'd1);
    i_rt = 32'd1;
    i_op = CMP_EQ;  settle(); chk("eq_equal", {31'd0, o_taken}, 32'd1);

    // Mispredict: predicted taken, BEQ with rs!=rt (pc 0x4008 -> idx 2)
    i_pc = 32'h4008; i_f_pc = 32'h4008;
    i_valid = 1'b1; i_is_branch = 1'b1; i_op = CMP_EQ;
    i_rs = 32'd1; i_rt = 32'd2; i_pred_taken = 1'b1;
    settle();
    chk("mp_comb_taken", {31'd0, o_taken}, 32'd0);
    chk("mp_comb", {31'd0, o_mispredict}, 32'd1);
    tick();
    exp_br = 32'd1; exp_mp = 32'd1;
    i_valid = 1'b0;
    settle();
    chk("mp_e_valid", {31'd0, o_e_valid}, 32'd1);
    chk("mp_e_taken", {31'd0, o_e_taken}, 32'd0);
    chk("mp_e_mispredict", {31'd0, o_e_mispredict}, 32'd1);
`ifdef CMP_STATS_EN
    chk("mp_br_cnt", o_br_cnt, 32'd1);
    chk("mp_mp_cnt", o_mp_cnt, 32'd1);
`else
    chk("mp_br_cnt_tied", o_br_cnt, 32'd0);
    chk("mp_mp_cnt_tied", o_mp_cnt, 32'd0);
`endif

    // Saturation at pc 0x3000 (idx 0), pred input held at 1
    i_pc = 32'h3000; i_f_pc = 32'h3000; i_pred_taken = 1'b1;
    i_valid = 1'b1; i_is_branch = 1'b1; i_op = CMP_EQ;
    i_rs = 32'd5; i_rt = 32'd5;
    settle();
    chk("sat_init_pred", {31'd0, o_f_pred_taken}, 32'd0);
    tick(); chk("sat_t1_pred", {31'd0, o_f_pred_taken}, 32'd1);
    tick(); tick(); tick();
    exp_br = exp_br + 32'd4;
    chk("sat_t4_pred", {31'd0, o_f_pred_taken}, 32'd1);
    i_rt = 32'd6;
    settle();
    chk("sat_nt_mp_comb", {31'd0, o_mispredict}, 32'd1);
    tick(); exp_br++; exp_mp++;
    chk("sat_nt1_pred", {31'd0, o_f_pred_taken}, 32'd1);
    tick(); exp_br++; exp_mp++;
    chk("sat_nt2_pred", {31'd0, o_f_pred_taken}, 32'd0);
    tick(); exp_br++; exp_mp++;
    tick(); exp_br++; exp_mp++;
    // One taken from 00 lands on 01, so prediction stays not-taken
    i_rt = 32'd5;
    tick(); exp_br++;
    chk("sat_floor_pred", {31'd0, o_f_pred_taken}, 32'd0);
`ifdef CMP_STATS_EN
    chk("sat_br_cnt", o_br_cnt, exp_br);
    chk("sat_mp_cnt", o_mp_cnt, exp_mp);
`else
    chk("sat_br_cnt_tied", o_br_cnt, 32'd0);
`endif

    // Collision at 0x3004 (idx 1, counter 01): no bypass
    i_pc = 32'h3004; i_f_pc = 32'h3004;
    i_rs = 32'd7; i_rt = 32'd7; i_pred_taken = 1'b1;
    settle();
    chk("coll_same_cycle", {31'd0, o_f_pred_taken}, 32'd0);
    tick(); exp_br++;
    i_valid = 1'b0;
    settle();
    chk("coll_next_cycle", {31'd0, o_f_pred_taken}, 32'd1);

    // Stall: taken branch at 0x300C (idx 3) must not update anything
    i_pc = 32'h300C; i_f_pc = 32'h300C;
    i_valid = 1'b1; i_op = CMP_NE; i_rs = 32'd1; i_rt = 32'd2;
    i_pred_taken = 1'b0; i_stall = 1'b1;
    settle();
    chk("stall_mp_comb", {31'd0, o_mispredict}, 32'd1);
    tick();
    chk("stall_pred", {31'd0, o_f_pred_taken}, 32'd0);
    chk("stall_e_valid", {31'd0, o_e_valid}, 32'd1);
    chk("stall_e_taken", {31'd0, o_e_taken}, 32'd1);
    chk("stall_e_mp", {31'd0, o_e_mispredict}, 32'd0);
`ifdef CMP_STATS_EN
    chk("stall_br_cnt", o_br_cnt, exp_br);
`else
    chk("stall_br_cnt_tied", o_br_cnt, 32'd0);
`endif
    // Flush over stall clears valid only
    i_flush = 1'b1;
    tick();
    chk("flush_e_valid", {31'd0, o_e_valid}, 32'd0);
    chk("flush_e_taken_hold", {31'd0, o_e_taken}, 32'd1);
    chk("flush_pred", {31'd0, o_f_pred_taken}, 32'd0);
    i_flush = 1'b0; i_stall = 1'b0;

    // Reset mid-update at 0x3000 (counter there is 01 -> taken would make it 10)
    i_pc = 32'h3000; i_f_pc = 32'h3000;
    i_op = CMP_EQ; i_rs = 32'd3; i_rt = 32'd3; i_valid = 1'b1; i_pred_taken = 1'b0;
    tick();
    chk("pre_rst_e_valid", {31'd0, o_e_valid}, 32'd1);
    chk("pre_rst_pred", {31'd0, o_f_pred_taken}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_e_valid", {31'd0, o_e_valid}, 32'd0);
    chk("rst_async_pred", {31'd0, o_f_pred_taken}, 32'd0);
    tick();
    i_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
    chk("post_rst_br_cnt", o_br_cnt, 32'd0);
    chk("post_rst_mp_cnt", o_mp_cnt, 32'd0);
    chk("post_rst_pred", {31'd0, o_f_pred_taken}, 32'd0);
    // One taken update from 01 shows the table really was reset
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    settle();
    chk("post_rst_one_taken", {31'd0, o_f_pred_taken}, 32'd1);
    i_f_pc = 32'h3004;
    settle();
    chk("post_rst_idx1", {31'd0, o_f_pred_taken}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
